operand_stage: RTL and testbench
================================

# operand_stage

Decode-to-execute pipeline stage of the core. Captures the decoded instruction and its two register-file read values, resolves operand hazards, and presents a registered operand/control bundle to execute. It uses forwarding from the MEM and WB stages, flags execute-stage bypass, and stalls on load-use. It sits directly downstream of the register file read ports and upstream of the ALU.

## Interface
- REGISTERS, 32, architectural register count; AW = $clog2(REGISTERS)
- WIDTH, 32, datapath width
- CTRL_W, 16, width of opaque execute-control bundle
---
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode slot holds an instruction
- id_rs1, id_rs2, id_rd  in  AW each  source/destination register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_reg_write, id_mem_read  in  1 each  writes rd / is a load
- id_ctrl  in  CTRL_W  passed through unmodified
- id_pc, id_imm  in  WIDTH each  passed through
- rf_rd1, rf_rd2  in  WIDTH each  register file read data (x0 already 0)
- mem_rd  in  AW; mem_reg_write  in  1; mem_result  in  WIDTH  MEM-stage forward source
- wb_rd  in  AW; wb_reg_write  in  1; wb_result  in  WIDTH  WB-stage source (same values drive register file write port)
- flush  in  1  kill the instruction entering execute
- stall  out  1  combinational; decode/fetch must hold
- ex_valid, ex_reg_write, ex_mem_read  out  1 each
- ex_rd  out  AW; ex_ctrl  out  CTRL_W; ex_pc, ex_imm  out  WIDTH
- ex_op_a, ex_op_b  out  WIDTH  resolved operands
- ex_fwd_a, ex_fwd_b  out  1 each  execute must substitute its own previous ALU result

## Operation
- Hit on operand r (rs1 or rs2): use_r && rs_r != 0 && stage_valid && stage_reg_write && stage_rd == rs_r. MEM and WB sources count as valid when their write enable is set.
- Operand resolution priority, evaluated per operand:
  1. rs == 0 or !use: value 0, fwd 0.
  2. Hit on current ex_* (the instruction in execute) and !ex_mem_read: fwd 1, value = rf value (don't-care).
  3. MEM hit: mem_result.
  4. WB hit: wb_result. This covers the same-cycle register-file write/read race.
  5. Otherwise: rf_rd.
- Load-use stall: stall = id_valid && ex_valid && ex_mem_read && hit on ex for either used operand && !flush.
- Registered update each edge, in priority order:
  1. rst: all outputs 0.
  2. flush: ex_valid <= 0 and ex_reg_write <= 0. Other fields don't-care, held at 0.
  3. stall: insert bubble. ex_valid, ex_reg_write, ex_mem_read <= 0.
  4. Otherwise: capture the id_* bundle, resolved operands and fwd flags. ex_valid <= id_valid. ex_reg_write and ex_mem_read are qualified by id_valid.
- Register index 0 never forwards and never stalls.

## Timing
- Latency: 1 cycle from id_* inputs to ex_* outputs.
- stall is combinational from id_*, ex_* registers and flush. Upstream samples it in the same cycle and replays the identical id_* bundle next cycle.
- A load-use pair costs exactly one bubble. On the next cycle the load has reached MEM and its result resolves via the MEM or WB path.
- Simultaneous events:
  - flush with stall: flush wins, stall deasserts.
  - MEM and WB hit on the same register: MEM wins (younger).
- Reset asserted mid-stream clears ex_valid immediately (asynchronous). The first instruction after deassertion is captured on the first rising edge.

## Structure
- core_pkg holds: REG_ADDR_W, WIDTH defaults, and the ex bundle struct (valid, rd, reg_write, mem_read, ctrl, pc, imm, op_a, op_b, fwd_a, fwd_b).
- Sub-module operand_resolve: combinational single-operand priority mux and hit logic. Outputs value, fwd and load_hit. Instantiated twice.
- The top holds the stall OR and the output register.

## Test plan
- Independent ops: id rs1=3, rs2=4, rf_rd1=0x11, rf_rd2=0x22, no hits -> next cycle ex_op_a=0x11, ex_op_b=0x22, ex_valid=1, stall=0.
- MEM/WB priority: rs1=5 with mem_rd=5 (mem_result=0xAA) and wb_rd=5 (wb_result=0xBB) -> ex_op_a=0xAA. With the MEM write disabled -> ex_op_a=0xBB.
- Load-use: ex holds a load to x7 and id uses rs2=7 -> stall=1 and ex_valid=0 next cycle. Replayed instruction resolves x7 from mem_result.
- ALU dependency: ex holds a non-load writing x9 and id rs1=9 -> stall=0, ex_fwd_a=1. Rs1=0 with ex_rd=0 -> ex_fwd_a=0, ex_op_a=0.
- Flush with stall: a load-use condition plus flush=1 -> stall=0, ex_valid=0 next cycle.
- Async reset mid-stream: assert rst between edges -> all ex_* outputs read 0 before the next edge.

Source files
------------

// File: rtl/operand_stage_pkg.sv
// Shared widths, the registered execute bundle and the register-hit helper
// for the decode-to-execute operand stage.
package operand_stage_pkg;

  localparam int unsigned REGISTERS  = 32;
  localparam int unsigned REG_ADDR_W = $clog2(REGISTERS);
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned CTRL_W     = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]      word_t;
  typedef logic [CTRL_W-1:0]     ctrl_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
    ctrl_t     ctrl;
    word_t     pc;
    word_t     imm;
    word_t     op_a;
    word_t     op_b;
    logic      fwd_a;
    logic      fwd_b;
  } ex_bundle_t;

  // x0 is hard-wired, so it never matches a producer.
  function automatic logic reg_hit(logic      use_rs,
                                   reg_addr_t rs,
                                   logic      wr_en,
                                   reg_addr_t rd);
    return use_rs && (rs != '0) && wr_en && (rd == rs);
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Decode/register-file/forwarding inputs and execute-bundle outputs of the
// operand stage. The stage itself uses the slave view.
interface operand_stage_if;
  import operand_stage_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  reg_addr_t id_rd;
  logic      id_use_rs1;
  logic      id_use_rs2;
  logic      id_reg_write;
  logic      id_mem_read;
  ctrl_t     id_ctrl;
  word_t     id_pc;
  word_t     id_imm;
  word_t     rf_rd1;
  word_t     rf_rd2;
  reg_addr_t mem_rd;
  logic      mem_reg_write;
  word_t     mem_result;
  reg_addr_t wb_rd;
  logic      wb_reg_write;
  word_t     wb_result;
  logic      flush;
  logic      stall;
  logic      ex_valid;
  logic      ex_reg_write;
  logic      ex_mem_read;
  reg_addr_t ex_rd;
  ctrl_t     ex_ctrl;
  word_t     ex_pc;
  word_t     ex_imm;
  word_t     ex_op_a;
  word_t     ex_op_b;
  logic      ex_fwd_a;
  logic      ex_fwd_b;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_mem_read, id_ctrl, id_pc, id_imm,
           rf_rd1, rf_rd2, mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result, flush,
    input  stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_ctrl,
           ex_pc, ex_imm, ex_op_a, ex_op_b, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_mem_read, id_ctrl, id_pc, id_imm,
           rf_rd1, rf_rd2, mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result, flush,
    output stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_ctrl,
           ex_pc, ex_imm, ex_op_a, ex_op_b, ex_fwd_a, ex_fwd_b
  );

endinterface

// File: rtl/operand_stage_resolve.sv
// Single-operand hazard resolution: picks zero, execute bypass, MEM, WB or
// register-file data, and flags a load in execute that the operand depends on.
module operand_stage_resolve
  import operand_stage_pkg::*;
(
  input  logic      use_i,
  input  reg_addr_t rs_i,
  input  word_t     rf_i,
  input  logic      ex_valid_i,
  input  logic      ex_reg_write_i,
  input  logic      ex_mem_read_i,
  input  reg_addr_t ex_rd_i,
  input  logic      mem_reg_write_i,
  input  reg_addr_t mem_rd_i,
  input  word_t     mem_result_i,
  input  logic      wb_reg_write_i,
  input  reg_addr_t wb_rd_i,
  input  word_t     wb_result_i,
  output word_t     value_o,
  output logic      fwd_o,
  output logic      load_hit_o
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = reg_hit(use_i, rs_i, ex_valid_i && ex_reg_write_i, ex_rd_i);
  assign mem_hit = reg_hit(use_i, rs_i, mem_reg_write_i, mem_rd_i);
  assign wb_hit  = reg_hit(use_i, rs_i, wb_reg_write_i, wb_rd_i);

  assign load_hit_o = ex_hit && ex_mem_read_i;

  always_comb begin
    value_o = rf_i;
    fwd_o   = 1'b0;
    if (!use_i || (rs_i == '0)) begin
      value_o = '0;
    end else if (ex_hit && !ex_mem_read_i) begin
      // Execute substitutes its own result; the carried value is unused.
      fwd_o = 1'b1;
    end else if (mem_hit) begin
      value_o = mem_result_i;
    end else if (wb_hit) begin
      value_o = wb_result_i;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute pipeline register with operand forwarding, execute
// bypass flags and a one-bubble load-use stall.
module operand_stage
  import operand_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  operand_stage_if.slave        bus_io
);

  ex_bundle_t ex_d;
  ex_bundle_t ex_q;

  word_t op_a;
  word_t op_b;
  logic  fwd_a;
  logic  fwd_b;
  logic  load_hit_a;
  logic  load_hit_b;
  logic  stall;

  operand_stage_resolve u_resolve_a (
    .use_i           (bus_io.id_use_rs1),
    .rs_i            (bus_io.id_rs1),
    .rf_i            (bus_io.rf_rd1),
    .ex_valid_i      (ex_q.valid),
    .ex_reg_write_i  (ex_q.reg_write),
    .ex_mem_read_i   (ex_q.mem_read),
    .ex_rd_i         (ex_q.rd),
    .mem_reg_write_i (bus_io.mem_reg_write),
    .mem_rd_i        (bus_io.mem_rd),
    .mem_result_i    (bus_io.mem_result),
    .wb_reg_write_i  (bus_io.wb_reg_write),
    .wb_rd_i         (bus_io.wb_rd),
    .wb_result_i     (bus_io.wb_result),
    .value_o         (op_a),
    .fwd_o           (fwd_a),
    .load_hit_o      (load_hit_a)
  );

  operand_stage_resolve u_resolve_b (
    .use_i           (bus_io.id_use_rs2),
    .rs_i            (bus_io.id_rs2),
    .rf_i            (bus_io.rf_rd2),
    .ex_valid_i      (ex_q.valid),
    .ex_reg_write_i  (ex_q.reg_write),
    .ex_mem_read_i   (ex_q.mem_read),
    .ex_rd_i         (ex_q.rd),
    .mem_reg_write_i (bus_io.mem_reg_write),
    .mem_rd_i        (bus_io.mem_rd),
    .mem_result_i    (bus_io.mem_result),
    .wb_reg_write_i  (bus_io.wb_reg_write),
    .wb_rd_i         (bus_io.wb_rd),
    .wb_result_i     (bus_io.wb_result),
    .value_o         (op_b),
    .fwd_o           (fwd_b),
    .load_hit_o      (load_hit_b)
  );

  // Flush overrides the stall so upstream does not hold a killed slot.
  assign stall = bus_io.id_valid && (load_hit_a || load_hit_b) && !bus_io.flush;

  // Flush and stall both load an all-zero bubble.
  always_comb begin
    ex_d = '0;
    if (!bus_io.flush && !stall) begin
      ex_d.valid     = bus_io.id_valid;
      ex_d.rd        = bus_io.id_rd;
      ex_d.reg_write = bus_io.id_valid && bus_io.id_reg_write;
      ex_d.mem_read  = bus_io.id_valid && bus_io.id_mem_read;
      ex_d.ctrl      = bus_io.id_ctrl;
      ex_d.pc        = bus_io.id_pc;
      ex_d.imm       = bus_io.id_imm;
      ex_d.op_a      = op_a;
      ex_d.op_b      = op_b;
      ex_d.fwd_a     = fwd_a;
      ex_d.fwd_b     = fwd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus_io.stall        = stall;
  assign bus_io.ex_valid     = ex_q.valid;
  assign bus_io.ex_reg_write = ex_q.reg_write;
  assign bus_io.ex_mem_read  = ex_q.mem_read;
  assign bus_io.ex_rd        = ex_q.rd;
  assign bus_io.ex_ctrl      = ex_q.ctrl;
  assign bus_io.ex_pc        = ex_q.pc;
  assign bus_io.ex_imm       = ex_q.imm;
  assign bus_io.ex_op_a      = ex_q.op_a;
  assign bus_io.ex_op_b      = ex_q.op_b;
  assign bus_io.ex_fwd_a     = ex_q.fwd_a;
  assign bus_io.ex_fwd_b     = ex_q.fwd_b;

endmodule

// File: tb/tb_operand_stage.sv
// Directed vector bench for operand_stage: forwarding priority, execute
// bypass, load-use bubble, flush-over-stall and asynchronous reset.
module tb_operand_stage;
  import operand_stage_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  operand_stage_if bus ();

  operand_stage dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, rw, mr;
    logic [31:0] rf1, rf2;
    logic [4:0]  mrd;
    logic        mwe;
    logic [31:0] mres;
    logic [4:0]  wrd;
    logic        wwe;
    logic [31:0] wres;
    logic        fl;
    logic        e_stall, e_valid, e_rw, e_mr;
    logic [4:0]  e_rd;
    logic        chk_ops;
    logic [31:0] e_a, e_b;
    logic        e_fa, e_fb;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t, input int idx);
    bus.id_valid      = t.v;
    bus.id_rs1        = t.rs1;
    bus.id_rs2        = t.rs2;
    bus.id_rd         = t.rd;
    bus.id_use_rs1    = t.u1;
    bus.id_use_rs2    = t.u2;
    bus.id_reg_write  = t.rw;
    bus.id_mem_read   = t.mr;
    bus.id_ctrl       = 16'hC000 | 16'(idx);
    bus.id_pc         = 32'h1000 + 32'(idx * 4);
    bus.id_imm        = 32'(idx * 3 + 1);
    bus.rf_rd1        = t.rf1;
    bus.rf_rd2        = t.rf2;
    bus.mem_rd        = t.mrd;
    bus.mem_reg_write = t.mwe;
    bus.mem_result    = t.mres;
    bus.wb_rd         = t.wrd;
    bus.wb_reg_write  = t.wwe;
    bus.wb_result     = t.wres;
    bus.flush         = t.fl;
  endtask

  initial begin
    vec_t idle;
    errors = 0;
    checks = 0;
    //          v rs1 rs2 rd u1 u2 rw mr rf1     rf2     mrd mwe mres      wrd wwe wres   fl
    //          stall valid rw mr rd chk a       b         fa fb
    vecs[0]  = '{1, 3, 4, 10, 1, 1, 1, 0, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 0,
                 0, 1, 1, 0, 10, 1, 'h11, 'h22, 0, 0};
    vecs[1]  = '{1, 5, 6, 11, 1, 1, 1, 0, 'h55, 'h66, 5, 1, 'hAA, 5, 1, 'hBB, 0,
                 0, 1, 1, 0, 11, 1, 'hAA, 'h66, 0, 0};
    vecs[2]  = '{1, 5, 6, 12, 1, 1, 1, 0, 'h55, 'h66, 5, 0, 'hAA, 5, 1, 'hBB, 0,
                 0, 1, 1, 0, 12, 1, 'hBB, 'h66, 0, 0};
    vecs[3]  = '{1, 12, 3, 13, 1, 1, 1, 0, 'h77, 'h33, 0, 0, 0, 0, 0, 0, 0,
                 0, 1, 1, 0, 13, 1, 'h77, 'h33, 1, 0};
    vecs[4]  = '{1, 0, 13, 0, 1, 1, 1, 0, 'h99, 'h44, 0, 0, 0, 0, 0, 0, 0,
                 0, 1, 1, 0, 0, 1, 0, 'h44, 0, 1};
    vecs[5]  = '{1, 0, 0, 7, 1, 1, 1, 1, 'h99, 'h98, 0, 0, 0, 0, 0, 0, 0,
                 0, 1, 1, 1, 7, 1, 0, 0, 0, 0};
    vecs[6]  = '{1, 3, 7, 8, 1, 1, 1, 0, 'h31, 'h70, 0, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 3, 7, 8, 1, 1, 1, 0, 'h31, 'h70, 7, 1, 'hDEAD, 0, 0, 0, 0,
                 0, 1, 1, 0, 8, 1, 'h31, 'hDEAD, 0, 0};
    vecs[8]  = '{1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 1, 1, 1, 9, 1, 0, 0, 0, 0};
    vecs[9]  = '{1, 9, 0, 2, 1, 0, 1, 0, 'h90, 0, 0, 0, 0, 0, 0, 0, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 1, 2, 4, 1, 1, 1, 1, 'h1, 'h2, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 4, 1, 'h1, 'h2, 0, 0};
    vecs[11] = '{1, 4, 4, 5, 0, 1, 0, 0, 'h40, 'h41, 0, 0, 0, 4, 1, 'hCC, 0,
                 0, 1, 0, 0, 5, 1, 0, 'hCC, 0, 0};
    vecs[12] = '{1, 4, 0, 6, 1, 0, 1, 0, 'h40, 'h41, 0, 0, 0, 4, 0, 'hCC, 0,
                 0, 1, 1, 0, 6, 1, 'h40, 0, 0, 0};
    vecs[13] = '{1, 0, 6, 3, 0, 1, 1, 0, 0, 'h61, 6, 1, 'h66, 0, 0, 0, 0,
                 0, 1, 1, 0, 3, 1, 0, 'h61, 0, 1};

    idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(idle, 0);
    rst = 1'b1;
    #1;
    chk("reset ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset ex_op_a", bus.ex_op_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i], i);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d ex_reg_write", i), 32'(bus.ex_reg_write), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d ex_mem_read", i), 32'(bus.ex_mem_read), 32'(vecs[i].e_mr));
      if (vecs[i].chk_ops) begin
        chk($sformatf("v%0d ex_rd", i), 32'(bus.ex_rd), 32'(vecs[i].e_rd));
        chk($sformatf("v%0d ex_op_a", i), bus.ex_op_a, vecs[i].e_a);
        chk($sformatf("v%0d ex_op_b", i), bus.ex_op_b, vecs[i].e_b);
        chk($sformatf("v%0d ex_fwd_a", i), 32'(bus.ex_fwd_a), 32'(vecs[i].e_fa));
        chk($sformatf("v%0d ex_fwd_b", i), 32'(bus.ex_fwd_b), 32'(vecs[i].e_fb));
        chk($sformatf("v%0d ex_pc", i), bus.ex_pc, 32'h1000 + 32'(i * 4));
        chk($sformatf("v%0d ex_imm", i), bus.ex_imm, 32'(i * 3 + 1));
        chk($sformatf("v%0d ex_ctrl", i), 32'(bus.ex_ctrl), 32'(16'hC000 | 16'(i)));
      end
    end

    // Asynchronous reset between edges while execute holds a valid op.
    drive('{1, 3, 0, 1, 1, 0, 1, 0, 'h5A, 0, 0, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 20);
    @(negedge clk);
    chk("pre-reset ex_valid", 32'(bus.ex_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("async ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
    chk("async ex_rd", 32'(bus.ex_rd), 32'd0);
    chk("async ex_op_b", bus.ex_op_b, 32'd0);
    chk("async ex_pc", bus.ex_pc, 32'd0);
    chk("async ex_fwd_b", 32'(bus.ex_fwd_b), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("post-reset ex_op_a", bus.ex_op_a, 32'h5A);
    chk("post-reset ex_rd", 32'(bus.ex_rd), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
